deserializer_aligner: RTL and testbench
=======================================

Name: deserializer_aligner

Overview:
Receive-side counterpart to the 10-bit serializer. Takes the MSB-first serial bitstream and finds 10-bit word boundaries by hunting for a comma symbol. It confirms alignment over several consecutive commas, then emits one aligned 10-bit word per 10 qualified bits. It also monitors commas that appear off the locked boundary and drops lock when too many occur.

Parameters:
COMMA_P, 10'b0011111010, positive-disparity comma (K28.5+), MSB-first
COMMA_N, 10'b1100000101, negative-disparity comma (K28.5-), MSB-first
LOCK_COMMAS, 3, consecutive boundary-aligned commas (including the first) required to enter LOCKED; range 1..15
MAX_ERR, 4, misaligned commas tolerated in LOCKED before dropping lock; range 1..15

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-high
serial_in  input  1  serial data, MSB of each word first
serial_valid  input  1  qualifies serial_in; a bit is consumed only on a clk edge with serial_valid=1
resync  input  1  synchronous request to return to HUNT
parallel_data  output  10  aligned received word; first-received bit in bit 9
data_valid  output  1  one-cycle pulse; parallel_data is valid
is_comma  output  1  qualifies parallel_data: word equals COMMA_P or COMMA_N; valid with data_valid
aligned  output  1  high while in LOCKED
align_lost  output  1  one-cycle pulse on an error-driven LOCKED->HUNT transition

Behaviour:
- Reset (async, active-high): state=HUNT; window, bit_cnt, comma_cnt, err_cnt = 0; all outputs 0.
- Window definition: nxt = {window[8:0], serial_in}. On each qualified edge, window <= nxt. hit = (nxt==COMMA_P || nxt==COMMA_N).
- bit_cnt counts 0..9 in VERIFY/LOCKED. A boundary is a qualified edge with bit_cnt==9; bit_cnt then wraps to 0.
- Edges with serial_valid=0 change nothing except the pulse outputs, which clear.
- data_valid and align_lost are registered pulses: high for exactly the one cycle after the causing edge, 0 otherwise.
- HUNT:
  - shift on every qualified bit; no data_valid.
  - on hit: bit_cnt<=0, comma_cnt<=1.
  - if LOCK_COMMAS==1, go to LOCKED; else go to VERIFY.
- VERIFY:
  - at each boundary with hit: comma_cnt+1; when the count reaches LOCK_COMMAS, go to LOCKED.
  - at a boundary without hit: go to HUNT, comma_cnt<=0.
  - no data_valid.
- LOCKED:
  - aligned=1.
  - at each boundary: parallel_data<=nxt, is_comma<=hit, data_valid pulse.
  - a boundary hit clears err_cnt.
  - a non-boundary hit increments err_cnt; reaching MAX_ERR goes to HUNT with an align_lost pulse, err_cnt<=0, aligned<=0.
  - latency: data_valid rises one cycle after the edge that samples the 10th bit of a word.
- aligned is registered from state; it rises the cycle after entry to LOCKED and falls the cycle after exit.
- resync=1 on any edge:
  - forces HUNT and clears bit_cnt, comma_cnt, err_cnt; window is retained.
  - no align_lost, no data_valid that cycle.
  - takes priority over every other event on the same edge, including a boundary.
- The first data word after lock is the 10 bits following the locking comma; the locking comma itself is not emitted.
- Reset mid-word discards partial data; no output is produced from pre-reset bits.

Test Plan:
- Reset, then 200 bits of alternating 0101... with serial_valid=1 -> aligned=0, data_valid never asserted.
- 3 random junk bits, 3x COMMA_P, then words 10'h2A5, 10'h17C -> aligned high after the 3rd comma; data_valid pulses twice, 10 cycles apart; parallel_data=10'h2A5 then 10'h17C; is_comma=0.
- Locked stream with serial_valid low for 4 cycles mid-word (bit 5), then resumed -> word reconstructed unchanged; data_valid delayed 4 cycles.
- While LOCKED, inject 4 commas straddling boundaries (offset 3 bits) interleaved with data -> align_lost pulses once after the 4th; aligned falls; a boundary comma between them resets the count, so no loss occurs.
- VERIFY with 2nd boundary word 10'h000 -> returns to HUNT; aligned stays 0.
- resync asserted on the same edge as a LOCKED boundary -> no data_valid, no align_lost, aligned falls next cycle.
- Async reset mid-word in LOCKED -> all outputs 0 immediately; relock requires LOCK_COMMAS fresh commas.

Source files
------------

// File: rtl/deserializer_aligner_if.sv
// Serial receive bus for deserializer_aligner: serial bit input side and aligned word output side.
// The master drives serial bits and resync; the slave returns aligned words and lock status.
interface deserializer_aligner_if;
   logic       serial_in;
   logic       serial_valid;
   logic       resync;
   logic [9:0] parallel_data;
   logic       data_valid;
   logic       is_comma;
   logic       aligned;
   logic       align_lost;

   modport master (
      output serial_in, serial_valid, resync,
      input  parallel_data, data_valid, is_comma, aligned, align_lost
   );

   modport slave (
      input  serial_in, serial_valid, resync,
      output parallel_data, data_valid, is_comma, aligned, align_lost
   );
endinterface

// File: rtl/deserializer_aligner.sv
// Comma-hunting 10-bit deserializer: locks onto K28.5 word boundaries, emits aligned words,
// and drops lock after too many commas appear off the locked boundary.
module deserializer_aligner #(
   parameter logic [9:0]  COMMA_P     = 10'b0011111010,
   parameter logic [9:0]  COMMA_N     = 10'b1100000101,
   parameter int unsigned LOCK_COMMAS = 3,
   parameter int unsigned MAX_ERR     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   deserializer_aligner_if.slave  bus
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
   localparam logic [3:0] ERR_N  = 4'(MAX_ERR);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t     state_reg, state_next;
   logic [9:0] window_reg, window_next;
   logic [3:0] bit_cnt_reg, bit_cnt_next;
   logic [3:0] comma_cnt_reg, comma_cnt_next;
   logic [3:0] err_cnt_reg, err_cnt_next;
   logic [9:0] parallel_data_reg, parallel_data_next;
   logic       data_valid_reg, data_valid_next;
   logic       is_comma_reg, is_comma_next;
   logic       aligned_reg, aligned_next;
   logic       align_lost_reg, align_lost_next;

   logic [9:0] nxt;
   logic       hit;
   logic       boundary;
   logic [3:0] bit_cnt_inc;

   assign nxt         = {window_reg[8:0], bus.serial_in};
   assign hit         = (nxt == COMMA_P) || (nxt == COMMA_N);
   assign boundary    = (bit_cnt_reg == 4'd9);
   assign bit_cnt_inc = boundary ? 4'd0 : bit_cnt_reg + 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= HUNT;
         window_reg        <= '0;
         bit_cnt_reg       <= '0;
         comma_cnt_reg     <= '0;
         err_cnt_reg       <= '0;
         parallel_data_reg <= '0;
         data_valid_reg    <= 1'b0;
         is_comma_reg      <= 1'b0;
         aligned_reg       <= 1'b0;
         align_lost_reg    <= 1'b0;
      end else begin
         state_reg         <= state_next;
         window_reg        <= window_next;
         bit_cnt_reg       <= bit_cnt_next;
         comma_cnt_reg     <= comma_cnt_next;
         err_cnt_reg       <= err_cnt_next;
         parallel_data_reg <= parallel_data_next;
         data_valid_reg    <= data_valid_next;
         is_comma_reg      <= is_comma_next;
         aligned_reg       <= aligned_next;
         align_lost_reg    <= align_lost_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      window_next        = window_reg;
      bit_cnt_next       = bit_cnt_reg;
      comma_cnt_next     = comma_cnt_reg;
      err_cnt_next       = err_cnt_reg;
      parallel_data_next = parallel_data_reg;
      is_comma_next      = is_comma_reg;
      data_valid_next    = 1'b0;
      align_lost_next    = 1'b0;

      if (bus.serial_valid) begin
         window_next = nxt;
      end

      // resync outranks everything on the same edge, including a boundary word
      if (bus.resync) begin
         state_next     = HUNT;
         bit_cnt_next   = '0;
         comma_cnt_next = '0;
         err_cnt_next   = '0;
      end else if (bus.serial_valid) begin
         case (state_reg)
            HUNT: begin
               if (hit) begin
                  bit_cnt_next   = '0;
                  comma_cnt_next = 4'd1;
                  err_cnt_next   = '0;
                  state_next     = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               bit_cnt_next = bit_cnt_inc;
               if (boundary) begin
                  if (hit) begin
                     comma_cnt_next = comma_cnt_reg + 4'd1;
                     if (comma_cnt_reg + 4'd1 == LOCK_N) begin
                        state_next = LOCKED;
                     end
                  end else begin
                     comma_cnt_next = '0;
                     state_next     = HUNT;
                  end
               end
            end
            LOCKED: begin
               bit_cnt_next = bit_cnt_inc;
               if (boundary) begin
                  parallel_data_next = nxt;
                  is_comma_next      = hit;
                  data_valid_next    = 1'b1;
                  if (hit) begin
                     err_cnt_next = '0;
                  end
               end else if (hit) begin
                  if (err_cnt_reg + 4'd1 == ERR_N) begin
                     state_next      = HUNT;
                     align_lost_next = 1'b1;
                     err_cnt_next    = '0;
                     comma_cnt_next  = '0;
                  end else begin
                     err_cnt_next = err_cnt_reg + 4'd1;
                  end
               end
            end
            default: state_next = HUNT;
         endcase
      end

      aligned_next = (state_next == LOCKED);
   end

   assign bus.parallel_data = parallel_data_reg;
   assign bus.data_valid    = data_valid_reg;
   assign bus.is_comma      = is_comma_reg;
   assign bus.aligned       = aligned_reg;
   assign bus.align_lost    = align_lost_reg;

endmodule

// File: tb/tb_deserializer_aligner.sv
// Directed bench for deserializer_aligner: hunt, lock, stall, misaligned commas, verify failure,
// resync and asynchronous reset, each scenario checked against hand-computed words and timing.
module tb_deserializer_aligner;

   localparam logic [9:0] COMMA_P = 10'b0011111010;

   logic clk;
   logic reset;

   deserializer_aligner_if bus();

   deserializer_aligner dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int         dv_count;
   int         lost_count;
   bit         aligned_seen;
   logic [9:0] dv_word[$];
   logic       dv_comma[$];
   int         dv_cyc[$];

   task automatic clear_mon();
      dv_count     = 0;
      lost_count   = 0;
      aligned_seen = 0;
      dv_word.delete();
      dv_comma.delete();
      dv_cyc.delete();
   endtask

   task automatic sample();
      cyc++;
      if (bus.data_valid) begin
         dv_count++;
         dv_word.push_back(bus.parallel_data);
         dv_comma.push_back(bus.is_comma);
         dv_cyc.push_back(cyc);
         $display("[TB] word %h is_comma=%b cycle %0d", bus.parallel_data, bus.is_comma, cyc);
      end
      if (bus.align_lost) lost_count++;
      if (bus.aligned) aligned_seen = 1;
   endtask

   // Inputs are held valid across exactly one rising edge, then released.
   task automatic drive_cycle(input logic b, input logic v, input logic rs);
      @(negedge clk);
      bus.serial_in    = b;
      bus.serial_valid = v;
      bus.resync       = rs;
      @(posedge clk);
      #1;
      sample();
      bus.serial_valid = 1'b0;
      bus.resync       = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      drive_cycle(b, 1'b1, 1'b0);
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 9; i >= 0; i--) send_bit(w[i]);
   endtask

   // 20 bits: "010", a comma, "0101010" -> comma ends 3 bits past a boundary
   task automatic send_straddle();
      logic [2:0] head;
      logic [6:0] tail;
      head = 3'b010;
      tail = 7'b0101010;
      for (int i = 2; i >= 0; i--) send_bit(head[i]);
      send_word(COMMA_P);
      for (int i = 6; i >= 0; i--) send_bit(tail[i]);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.aligned !== 1'b0) begin fails++; $display("FAIL reset_aligned: got %b want 0", bus.aligned); end
      tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL reset_data_valid: got %b want 0", bus.data_valid); end
      tests++; if (bus.parallel_data !== 10'h000) begin fails++; $display("FAIL reset_parallel_data: got %h want 000", bus.parallel_data); end
      tests++; if (bus.is_comma !== 1'b0) begin fails++; $display("FAIL reset_is_comma: got %b want 0", bus.is_comma); end
      tests++; if (bus.align_lost !== 1'b0) begin fails++; $display("FAIL reset_align_lost: got %b want 0", bus.align_lost); end
      @(negedge clk);
      reset = 1'b0;
      clear_mon();
      for (int i = 0; i < 200; i++) send_bit(logic'(i % 2));
      tests++; if (dv_count !== 0) begin fails++; $display("FAIL alt_no_data_valid: got %0d pulses want 0", dv_count); end
      tests++; if (aligned_seen !== 1'b0) begin fails++; $display("FAIL alt_never_aligned: got %b want 0", aligned_seen); end
      tests++; if (lost_count !== 0) begin fails++; $display("FAIL alt_no_align_lost: got %0d want 0", lost_count); end
   endtask

   task automatic test_lock();
      int         w1_cyc;
      logic [9:0] w0, w1;
      logic       c0, c1;
      int         d0, d1;
      clear_mon();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_word(COMMA_P);
      send_word(COMMA_P);
      tests++; if (bus.aligned !== 1'b0) begin fails++; $display("FAIL lock_after_2_commas: aligned=%b want 0", bus.aligned); end
      send_word(COMMA_P);
      tests++; if (bus.aligned !== 1'b1) begin fails++; $display("FAIL lock_after_3_commas: aligned=%b want 1", bus.aligned); end
      tests++; if (dv_count !== 0) begin fails++; $display("FAIL lock_comma_not_emitted: got %0d pulses want 0", dv_count); end
      send_word(10'h2A5);
      w1_cyc = cyc;
      send_word(10'h17C);
      w0 = (dv_word.size() > 0) ? dv_word[0] : 'x;
      w1 = (dv_word.size() > 1) ? dv_word[1] : 'x;
      c0 = (dv_comma.size() > 0) ? dv_comma[0] : 1'bx;
      c1 = (dv_comma.size() > 1) ? dv_comma[1] : 1'bx;
      d0 = (dv_cyc.size() > 0) ? dv_cyc[0] : -1;
      d1 = (dv_cyc.size() > 1) ? dv_cyc[1] : -1;
      tests++; if (dv_count !== 2) begin fails++; $display("FAIL lock_pulse_count: got %0d want 2", dv_count); end
      tests++; if (w0 !== 10'h2A5) begin fails++; $display("FAIL lock_word0: got %h want 2a5", w0); end
      tests++; if (w1 !== 10'h17C) begin fails++; $display("FAIL lock_word1: got %h want 17c", w1); end
      tests++; if ({c0, c1} !== 2'b00) begin fails++; $display("FAIL lock_is_comma: got %b%b want 00", c0, c1); end
      tests++; if (d0 !== w1_cyc) begin fails++; $display("FAIL lock_latency: pulse cycle %0d want %0d", d0, w1_cyc); end
      tests++; if (d1 - d0 !== 10) begin fails++; $display("FAIL lock_spacing: got %0d want 10", d1 - d0); end
   endtask

   task automatic test_stall();
      int         start;
      logic [9:0] w;
      logic [9:0] got;
      int         got_cyc;
      clear_mon();
      w = 10'h3C3;
      start = cyc;
      for (int i = 9; i >= 5; i--) send_bit(w[i]);
      repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
      for (int i = 4; i >= 0; i--) send_bit(w[i]);
      got     = (dv_word.size() > 0) ? dv_word[0] : 'x;
      got_cyc = (dv_cyc.size() > 0) ? dv_cyc[0] : -1;
      tests++; if (dv_count !== 1) begin fails++; $display("FAIL stall_pulse_count: got %0d want 1", dv_count); end
      tests++; if (got !== 10'h3C3) begin fails++; $display("FAIL stall_word: got %h want 3c3", got); end
      tests++; if (got_cyc !== start + 14) begin fails++; $display("FAIL stall_timing: pulse cycle %0d want %0d", got_cyc, start + 14); end
      tests++; if (bus.aligned !== 1'b1) begin fails++; $display("FAIL stall_aligned: got %b want 1", bus.aligned); end
   endtask

   task automatic test_misaligned();
      logic [9:0] w0;
      logic       c6;
      clear_mon();
      repeat (3) send_straddle();
      send_word(COMMA_P);
      repeat (3) send_straddle();
      w0 = (dv_word.size() > 0) ? dv_word[0] : 'x;
      c6 = (dv_comma.size() > 6) ? dv_comma[6] : 1'bx;
      tests++; if (lost_count !== 0) begin fails++; $display("FAIL misalign_cleared_no_loss: got %0d pulses want 0", lost_count); end
      tests++; if (bus.aligned !== 1'b1) begin fails++; $display("FAIL misalign_still_aligned: got %b want 1", bus.aligned); end
      tests++; if (dv_count !== 13) begin fails++; $display("FAIL misalign_word_count: got %0d want 13", dv_count); end
      tests++; if (w0 !== 10'h11F) begin fails++; $display("FAIL misalign_straddle_word: got %h want 11f", w0); end
      tests++; if (c6 !== 1'b1) begin fails++; $display("FAIL misalign_boundary_is_comma: got %b want 1", c6); end
      clear_mon();
      send_straddle();
      tests++; if (lost_count !== 1) begin fails++; $display("FAIL misalign_loss_pulse: got %0d cycles want 1", lost_count); end
      tests++; if (bus.aligned !== 1'b0) begin fails++; $display("FAIL misalign_aligned_fall: got %b want 0", bus.aligned); end
      tests++; if (dv_count !== 1) begin fails++; $display("FAIL misalign_words_before_loss: got %0d want 1", dv_count); end
   endtask

   task automatic test_verify_fail();
      clear_mon();
      send_word(COMMA_P);
      send_word(10'h000);
      send_word(COMMA_P);
      send_word(COMMA_P);
      tests++; if (bus.aligned !== 1'b0) begin fails++; $display("FAIL verify_fail_rehunt: aligned=%b want 0", bus.aligned); end
      tests++; if (aligned_seen !== 1'b0) begin fails++; $display("FAIL verify_fail_never_aligned: got %b want 0", aligned_seen); end
      send_word(COMMA_P);
      tests++; if (bus.aligned !== 1'b1) begin fails++; $display("FAIL verify_fail_relock: aligned=%b want 1", bus.aligned); end
      tests++; if (dv_count !== 0) begin fails++; $display("FAIL verify_fail_no_data: got %0d pulses want 0", dv_count); end
   endtask

   task automatic test_resync();
      logic [9:0] w;
      logic [9:0] got;
      clear_mon();
      w = 10'h2A5;
      for (int i = 9; i >= 1; i--) send_bit(w[i]);
      drive_cycle(w[0], 1'b1, 1'b1);
      tests++; if (dv_count !== 0) begin fails++; $display("FAIL resync_no_data_valid: got %0d pulses want 0", dv_count); end
      tests++; if (lost_count !== 0) begin fails++; $display("FAIL resync_no_align_lost: got %0d want 0", lost_count); end
      tests++; if (bus.aligned !== 1'b0) begin fails++; $display("FAIL resync_aligned_fall: got %b want 0", bus.aligned); end
      clear_mon();
      send_word(COMMA_P);
      send_word(COMMA_P);
      send_word(COMMA_P);
      send_word(10'h155);
      got = (dv_word.size() > 0) ? dv_word[0] : 'x;
      tests++; if (dv_count !== 1 || got !== 10'h155) begin fails++; $display("FAIL resync_relock_word: got %0d pulses word %h want 1 pulse word 155", dv_count, got); end
   endtask

   task automatic test_async_reset();
      logic [9:0] w;
      logic [9:0] got;
      clear_mon();
      send_word(10'h2A5);
      tests++; if (bus.parallel_data !== 10'h2A5) begin fails++; $display("FAIL areset_pre_word: got %h want 2a5", bus.parallel_data); end
      w = 10'h17C;
      for (int i = 9; i >= 5; i--) send_bit(w[i]);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests++; if (bus.aligned !== 1'b0) begin fails++; $display("FAIL areset_aligned: got %b want 0", bus.aligned); end
      tests++; if (bus.parallel_data !== 10'h000) begin fails++; $display("FAIL areset_parallel_data: got %h want 000", bus.parallel_data); end
      tests++; if ({bus.data_valid, bus.is_comma, bus.align_lost} !== 3'b000) begin fails++; $display("FAIL areset_pulses: got %b want 000", {bus.data_valid, bus.is_comma, bus.align_lost}); end
      @(negedge clk);
      reset = 1'b0;
      clear_mon();
      for (int i = 4; i >= 0; i--) send_bit(w[i]);
      send_word(COMMA_P);
      send_word(COMMA_P);
      tests++; if (bus.aligned !== 1'b0) begin fails++; $display("FAIL areset_needs_fresh_commas: aligned=%b want 0", bus.aligned); end
      send_word(COMMA_P);
      tests++; if (bus.aligned !== 1'b1) begin fails++; $display("FAIL areset_relock: aligned=%b want 1", bus.aligned); end
      send_word(10'h155);
      got = (dv_word.size() > 0) ? dv_word[0] : 'x;
      tests++; if (dv_count !== 1 || got !== 10'h155) begin fails++; $display("FAIL areset_first_word: got %0d pulses word %h want 1 pulse word 155", dv_count, got); end
   endtask

   initial begin
      reset            = 1'b1;
      bus.serial_in    = 1'b0;
      bus.serial_valid = 1'b0;
      bus.resync       = 1'b0;
      clear_mon();
      test_reset();
      test_lock();
      test_stall();
      test_misaligned();
      test_verify_fail();
      test_resync();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
